// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache refill / write-back bus: default widths,
// one-hot arbiter states and the grant encoding used by both caches.
package cache_bus_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 64;
  localparam int LINE_BEATS_DEF = 4;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_I_RD    = 5'b00010,
    ST_D_RD    = 5'b00100,
    ST_D_WR    = 5'b01000,
    ST_D_WRESP = 5'b10000
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin arbiter: on a tie the side not granted last wins;
// the remembered grant updates only on an enabled grant edge.
module arb_rr2
  import cache_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_grant_en,
  output gnt_t o_gnt,
  output logic o_any
);

  gnt_t r_last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GNT_I;
    end else if (i_grant_en && o_any) begin
      r_last_grant <= o_gnt;
    end
  end

  always_comb begin
    o_any = i_req_ic | i_req_dc;
    if (i_req_ic && i_req_dc) begin
      o_gnt = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (i_req_dc) begin
      o_gnt = GNT_D;
    end else begin
      o_gnt = GNT_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory-bus master port between the icache refill path and the
// dcache refill/write-back path, one line-sized burst at a time.
module cache_mem_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_BEATS = LINE_BEATS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_wready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_done,
  output logic                m_req,
  input  logic                m_ack,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [7:0]          m_len,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  input  logic                m_rlast,
  input  logic                m_bok,
  output logic                err
);

  localparam int              CNT_W     = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_m_req, r_m_we, r_ack_seen, r_err;
  logic [ADDR_W-1:0]  r_m_addr;
  logic               w_err_set, w_wacc, w_any, w_grant_en;
  gnt_t               w_gnt;

  arb_rr2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_ic   (i_req),
    .i_req_dc   (d_req),
    .i_grant_en (w_grant_en),
    .o_gnt      (w_gnt),
    .o_any      (w_any)
  );

  assign w_grant_en = (r_state == ST_IDLE);
  assign m_req      = r_m_req;
  assign m_we       = r_m_we;
  assign m_addr     = r_m_addr;
  assign err        = r_err;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_set    = 1'b0;
    w_wacc       = 1'b0;
    i_rdata      = '0;
    i_rvalid     = 1'b0;
    i_done       = 1'b0;
    d_rdata      = '0;
    d_rvalid     = 1'b0;
    d_done       = 1'b0;
    d_wready     = 1'b0;
    m_len        = 8'd0;
    m_wdata      = '0;
    m_wstrb      = '0;
    m_wvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          if (w_gnt == GNT_I)  w_state_next = ST_I_RD;
          else if (d_we)       w_state_next = ST_D_WR;
          else                 w_state_next = ST_D_RD;
        end
      end
      ST_I_RD, ST_D_RD: begin
        m_len = 8'(LINE_BEATS - 1);
        if (r_state == ST_I_RD) begin
          i_rdata  = m_rdata;
          i_rvalid = m_rvalid;
          i_done   = m_rvalid & m_rlast;
        end else begin
          d_rdata  = m_rdata;
          d_rvalid = m_rvalid;
          d_done   = m_rvalid & m_rlast;
        end
        // A missing rlast at the final count is flagged; the counter holds
        // there while we keep waiting for the bridge to close the burst.
        if (m_rvalid) begin
          if (m_rlast) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_err_set    = (r_cnt != LAST_BEAT);
          end else if (r_cnt == LAST_BEAT) begin
            w_err_set = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_D_WR: begin
        m_len    = 8'(LINE_BEATS - 1);
        m_wvalid = r_ack_seen;
        m_wdata  = d_wdata;
        m_wstrb  = d_wstrb;
        w_wacc   = r_ack_seen & m_wready;
        d_wready = w_wacc;
        if (w_wacc) begin
          if (r_cnt == LAST_BEAT) begin
            w_cnt_next   = '0;
            w_state_next = ST_D_WRESP;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_D_WRESP: begin
        m_len  = 8'(LINE_BEATS - 1);
        d_done = m_bok;
        if (m_bok) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_ack_seen <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_err_set) r_err <= 1'b1;
      if (r_state == ST_IDLE && w_any) begin
        r_m_req    <= 1'b1;
        r_m_we     <= (w_gnt == GNT_D) & d_we;
        r_m_addr   <= (w_gnt == GNT_D) ? d_addr : i_addr;
        r_ack_seen <= 1'b0;
      end else if (r_m_req && m_ack) begin
        r_m_req    <= 1'b0;
        r_ack_seen <= 1'b1;
      end
    end
  end

endmodule
